// File: rtl/arm1_param_core.sv
// -----------------------------------------------------------------------------
// arm1_param_core
//
// Parametrised ARM1-style multicycle accumulator processor. The datapath,
// control FSM and unified memory all live in this one block.
//
// Every instruction walks FETCH -> DECODE -> EXEC -> FETCH, so it takes exactly
// 3 cycles. HLT is the exception: it is caught in DECODE and parks the core
// in HALT until the next reset.
//
// Instruction word layout:
//   opcode = word[DATA_W-1 -: 4]
//   addr   = word[ADDR_W-1:0]
//   Any bits in between are ignored.
//
// Parameters:
//   DATA_W : datapath and memory word width. Must be >= ADDR_W + 4 so that
//            the opcode and address fields do not overlap.
//   ADDR_W : address width. Memory depth is 2**ADDR_W words.
//
// Optional feature:
//   ARM1_IMM_EN. When this macro is defined, two immediate opcodes exist:
//     0x5 LDI  : AC <= zero-extended addr (flags kept)
//     0x6 ADDI : AC <= AC + zero-extended addr (flags as for ADD)
//   When it is undefined, 0x5 and 0x6 behave as NOPs.
//
// Ports:
//   clk        : system clock; all state updates on the rising edge
//   reset      : synchronous, active-high reset
//   prog_we    : program-port write enable; honoured only while reset=1
//   prog_addr  : program-port word address
//   prog_data  : program-port write data
//   pc_out     : current PC
//   ac_out     : accumulator
//   b_out      : B register
//   o_out      : output register
//   o_valid    : one-cycle pulse, in the cycle after O is written
//   flags      : {Z,N,C,V}
//   halted     : core is in the HALT state
//   instr_done : one-cycle pulse after the EXEC of each retired instruction
//
// Strobe semantics: o_valid and instr_done are registered single-cycle
// pulses. There is no ready/back-pressure. A consumer must capture o_out in
// the cycle o_valid is high; o_out then holds its value until the next OUT.
// -----------------------------------------------------------------------------
module arm1_param_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ac_out,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] o_out,
  output logic              o_valid,
  output logic [3:0]        flags,
  output logic              halted,
  output logic              instr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MSB   = DATA_W - 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_HLT  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JN   = 4'hA;
  localparam logic [3:0] OP_LDA  = 4'hC;
  localparam logic [3:0] OP_LDB  = 4'hD;
  localparam logic [3:0] OP_STA  = 4'hE;
  localparam logic [3:0] OP_OUT  = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  // Current FSM state. It is kept as a named signal so that checkers can
  // bind to it.
  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [3:0]        ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ac;
  logic [DATA_W-1:0] b;

  // EXEC-stage results, computed combinationally from IR, AC, B and memory.
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] add_opnd;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] ac_nxt;
  logic              ac_we;
  logic              flag_we;
  logic              c_nxt;
  logic              v_nxt;
  logic [DATA_W-1:0] mem_at_addr;
  logic [DATA_W-1:0] addr_zext;

  assign mem_at_addr = mem[ir_addr];
  assign addr_zext   = {{(DATA_W-ADDR_W){1'b0}}, ir_addr};

`ifdef ARM1_IMM_EN
  assign add_opnd = (ir_op == OP_ADDI) ? addr_zext : b;
`else
  assign add_opnd = b;
`endif

  always_comb begin
    sum     = {1'b0, ac} + {1'b0, add_opnd};
    diff    = {1'b0, ac} - {1'b0, b};
    res     = '0;
    ac_nxt  = ac;
    ac_we   = 1'b0;
    flag_we = 1'b0;
    c_nxt   = 1'b0;
    v_nxt   = 1'b0;
    case (ir_op)
      OP_ADD: begin
        res     = sum[MSB:0];
        c_nxt   = sum[DATA_W];
        // Signed overflow: both operands share a sign that the result lacks.
        v_nxt   = (ac[MSB] == add_opnd[MSB]) && (res[MSB] != ac[MSB]);
        ac_nxt  = res;
        ac_we   = 1'b1;
        flag_we = 1'b1;
      end
      OP_SUB: begin
        res     = diff[MSB:0];
        // The borrow is the top bit of the widened difference.
        // Carry means "no borrow", i.e. AC >= B unsigned.
        c_nxt   = ~diff[DATA_W];
        v_nxt   = (ac[MSB] != b[MSB]) && (res[MSB] != ac[MSB]);
        ac_nxt  = res;
        ac_we   = 1'b1;
        flag_we = 1'b1;
      end
      OP_AND: begin
        res     = ac & b;
        ac_nxt  = res;
        ac_we   = 1'b1;
        flag_we = 1'b1;
      end
      OP_OR: begin
        res     = ac | b;
        ac_nxt  = res;
        ac_we   = 1'b1;
        flag_we = 1'b1;
      end
      OP_XOR: begin
        res     = ac ^ b;
        ac_nxt  = res;
        ac_we   = 1'b1;
        flag_we = 1'b1;
      end
`ifdef ARM1_IMM_EN
      OP_LDI: begin
        ac_nxt = addr_zext;
        ac_we  = 1'b1;
      end
      OP_ADDI: begin
        res     = sum[MSB:0];
        c_nxt   = sum[DATA_W];
        v_nxt   = (ac[MSB] == add_opnd[MSB]) && (res[MSB] != ac[MSB]);
        ac_nxt  = res;
        ac_we   = 1'b1;
        flag_we = 1'b1;
      end
`endif
      OP_LDA: begin
        ac_nxt = mem_at_addr;
        ac_we  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Control FSM and architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= '0;
      ac         <= '0;
      b          <= '0;
      o_out      <= '0;
      o_valid    <= 1'b0;
      flags      <= 4'b0000;
      halted     <= 1'b0;
      instr_done <= 1'b0;
      ir_op      <= 4'h0;
      ir_addr    <= '0;
    end else begin
      o_valid    <= 1'b0;
      instr_done <= 1'b0;
      case (state)
        S_FETCH: begin
          ir_op   <= mem[pc][DATA_W-1 -: 4];
          ir_addr <= mem[pc][ADDR_W-1:0];
          pc      <= pc + 1'b1;  // wraps modulo 2**ADDR_W
          state   <= S_DECODE;
        end
        S_DECODE: begin
          if (ir_op == OP_HLT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state      <= S_FETCH;
          instr_done <= 1'b1;
          if (ac_we) ac <= ac_nxt;
          if (flag_we) flags <= {(res == '0), res[MSB], c_nxt, v_nxt};
          case (ir_op)
            OP_JMP: pc <= ir_addr;
            // Jumps test the flags as they stand entering EXEC.
            OP_JZ:  if (flags[3]) pc <= ir_addr;
            OP_JN:  if (flags[2]) pc <= ir_addr;
            OP_LDB: b <= mem_at_addr;
            OP_OUT: begin
              o_out   <= ac;
              o_valid <= 1'b1;
            end
            default: begin
            end
          endcase
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

  // Unified memory. There is no reset of its contents.
  // The program port is live only while in reset. A reset during an STA
  // EXEC cycle suppresses that store. A store completes before the next
  // FETCH, so self-modifying code sees the new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (prog_we) mem[prog_addr] <= prog_data;
    end else if (state == S_EXEC && ir_op == OP_STA) begin
      mem[ir_addr] <= ac;
    end
  end

  assign pc_out = pc;
  assign ac_out = ac;
  assign b_out  = b;

endmodule

// File: doc/arm1_param_core.md
Name: arm1_param_core

Overview:
- Parametrised next-generation ARM1 multicycle accumulator processor (datapath, control FSM and unified memory in one block).
- Widens data and address beyond 8/4 bits.
- Adds XOR, a registered Z/N/C/V flag register, conditional/unconditional jumps, HLT and an output-valid strobe.
- Memory is loaded through a program port while held in reset; all architectural state is exposed for verification.

Parameters:
DATA_W, 8, datapath and memory word width; must satisfy DATA_W >= ADDR_W + 4
ADDR_W, 4, address width; memory depth = 2**ADDR_W words

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
prog_we  input  1  program-port write enable; honoured only while reset=1
prog_addr  input  ADDR_W  program-port word address
prog_data  input  DATA_W  program-port write data
pc_out  output  ADDR_W  current PC
ac_out  output  DATA_W  accumulator
b_out  output  DATA_W  B register
o_out  output  DATA_W  output register
o_valid  output  1  one-cycle pulse when O is written
flags  output  4  {Z,N,C,V}
halted  output  1  core in HALT state
instr_done  output  1  one-cycle pulse at end of each retired instruction

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Instruction word:
  - opcode = bits [DATA_W-1:DATA_W-4].
  - addr = bits [ADDR_W-1:0].
  - Any remaining bits are ignored.
- Reset values: PC, AC, B, O, flags, o_valid, halted and instr_done all = 0; state = FETCH.
- Memory contents are not affected by reset.
- Memory: 2**ADDR_W x DATA_W array, combinational read, write on rising edge.
  - While reset=1 and prog_we=1: M[prog_addr] <= prog_data.
  - prog_we is ignored when reset=0.
- FSM: FETCH -> DECODE -> EXEC -> FETCH. Every instruction takes exactly 3 cycles, except HLT.
  - FETCH: IR <= M[PC]; PC <= PC+1, wrapping modulo 2**ADDR_W.
  - DECODE: opcode 0x7 moves to HALT; all other opcodes move to EXEC.
  - EXEC: performs the opcode, then pulses instr_done for the following cycle.
  - HALT: absorbing state; halted=1; leaves only on reset.
- Opcodes (executed in EXEC):
  - 0x0 ADD: AC <= AC+B
  - 0x1 SUB: AC <= AC-B
  - 0x2 AND, 0x3 OR, 0x4 XOR: AC <= AC op B
  - 0x8 JMP: PC <= addr
  - 0x9 JZ: PC <= addr if Z=1
  - 0xA JN: PC <= addr if N=1
  - 0xC LDA: AC <= M[addr]
  - 0xD LDB: B <= M[addr]
  - 0xE STA: M[addr] <= AC
  - 0xF OUT: O <= AC; o_valid=1 in the next cycle
  - 0x7 HLT: handled in DECODE (see FSM)
  - All other opcodes: NOP, still 3 cycles with an instr_done pulse.
- Flags: updated only by ALU opcodes 0x0–0x4; all other opcodes preserve them.
  - Z = result==0.
  - N = result MSB.
  - ADD: C = carry out of bit DATA_W-1; V = signed overflow.
  - SUB: C = 1 when AC >= B unsigned (no borrow); V = signed overflow.
  - Logical ops (AND/OR/XOR): C=0, V=0.
- Arithmetic: results truncated to DATA_W bits. Jumps read flags as they stand at EXEC.
- Reset mid-instruction: the instruction is abandoned, its architectural write is suppressed, and reset values are restored on that edge.
- A self-modifying STA to the next fetch address is visible to that fetch (write precedes the next FETCH).

Optional Feature:
- Macro: ARM1_IMM_EN.
- Defined:
  - 0x5 LDI: AC <= zero-extended addr; flags unchanged.
  - 0x6 ADDI: AC <= AC + zero-extended addr; flags updated as for ADD.
- Undefined: 0x5 and 0x6 are NOPs.

Test Plan:
- Load program with reset=1, then release reset.
  - Program: M0=0xCA, M1=0xDB, M2=0x00, M3=0xF0, M4=0x70, M10=0x05, M11=0x03.
  - Required: o_valid high for one cycle after the 12th edge with o_out=0x08.
  - Required: halted=1 after the 14th edge; pc_out=5 thereafter, and it stays.
- Flags on ADD overflow: AC=0x7F, B=0x01, ADD -> AC=0x80, flags Z=0 N=1 C=0 V=1.
- Flags on SUB: 0x05-0x05 -> AC=0x00, Z=1 C=1.
- Flags on SUB with borrow: 0x03-0x05 -> AC=0xFE, N=1 C=0.
- Branches:
  - JZ 0x9 with Z=1 -> pc_out=9 after EXEC.
  - JZ with Z=0 -> PC sequential.
  - JMP 0x0 at address 15 (ADDR_W=4) -> PC=0; plain fetch at 15 wraps to 0.
- STA/LDA round trip: STA 0xE8 with AC=0xA5, then LDA 0xC8 after clearing AC -> ac_out=0xA5.
  - prog_we pulsed with reset=0 leaves memory unchanged.
- Reset mid-EXEC of STA -> target word unchanged; all outputs zero on the next cycle.
- With ARM1_IMM_EN defined: LDI 0x53 then ADDI 0x6F -> AC=0x12.
- With ARM1_IMM_EN undefined: the same program leaves AC=0 and still produces 2 instr_done pulses.
